i4003_ext: RTL and testbench

//  Parametrised successor to the MCS-4 4003 serial-in/parallel-out shift register,

---
 rtl/i4003_ext.sv | 112 +++++++++++
 tb/tb_i4003_ext.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i4003_ext.sv
// Parametrised 4003-style serial-in/parallel-out shift register with a
// synchronised, settle-delay-filtered shift clock and optional output hold register.
module i4003_ext #(
    parameter int SYSCLK_TCY     = 20,
    parameter int LATCH_DELAY_NS = 250,
    parameter int WIDTH          = 10,
    parameter int SHIFT_MSB      = 1,
    parameter int LATCHED        = 0
) (
    input  logic             sysclk,
    input  logic             poc,
    input  logic             cp,
    input  logic             serial_in,
    input  logic             clear,
    input  logic             strobe,
    input  logic             enable,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic             full
);

    localparam int DLY = (LATCH_DELAY_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int CW  = (DLY < 1) ? 1 : $clog2(DLY + 1);
    localparam int FW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] DLY_C  = CW'(DLY);
    localparam logic [FW-1:0] FULL_C = FW'(WIDTH);

    logic             cp_s1_q, cp_s1_d;
    logic             cp_s2_q, cp_s2_d;
    logic             cp_acc_q, cp_acc_d;
    logic [CW-1:0]    dly_cnt_q, dly_cnt_d;
    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             serial_out_q, serial_out_d;
    logic [FW-1:0]    fill_cnt_q, fill_cnt_d;

    logic             accept;
    logic             rise;
    logic             fall;
    logic             end_bit;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        cp_s1_d   = cp;
        cp_s2_d   = cp_s1_q;
        cp_acc_d  = cp_acc_q;
        dly_cnt_d = '0;
        accept    = 1'b0;
        // A level must persist through DLY+1 consecutive samples to be accepted.
        if (cp_s2_q != cp_acc_q) begin
            if (dly_cnt_q == DLY_C) begin
                accept   = 1'b1;
                cp_acc_d = cp_s2_q;
            end else begin
                dly_cnt_d = dly_cnt_q + 1'b1;
            end
        end
        rise = accept & cp_s2_q;
        fall = accept & ~cp_s2_q;

        if (SHIFT_MSB != 0) begin
            shifted = {shifter_q[WIDTH-2:0], serial_in};
            end_bit = shifter_q[WIDTH-1];
        end else begin
            shifted = {serial_in, shifter_q[WIDTH-1:1]};
            end_bit = shifter_q[0];
        end

        shifter_d  = shifter_q;
        fill_cnt_d = fill_cnt_q;
        if (clear) begin
            shifter_d  = '0;
            fill_cnt_d = '0;
        end else if (rise) begin
            shifter_d = shifted;
            if (fill_cnt_q != FULL_C) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
        end

        // Falling edge publishes the pre-clear end bit: slave half of the chain.
        serial_out_d = fall ? end_bit : serial_out_q;
        hold_d       = ((LATCHED != 0) && strobe) ? shifter_d : hold_q;
    end

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            cp_s1_q      <= 1'b0;
            cp_s2_q      <= 1'b0;
            cp_acc_q     <= 1'b0;
            dly_cnt_q    <= '0;
            shifter_q    <= '0;
            hold_q       <= '0;
            serial_out_q <= 1'b0;
            fill_cnt_q   <= '0;
        end else begin
            cp_s1_q      <= cp_s1_d;
            cp_s2_q      <= cp_s2_d;
            cp_acc_q     <= cp_acc_d;
            dly_cnt_q    <= dly_cnt_d;
            shifter_q    <= shifter_d;
            hold_q       <= hold_d;
            serial_out_q <= serial_out_d;
            fill_cnt_q   <= fill_cnt_d;
        end
    end

    assign parallel_out = enable ? ((LATCHED != 0) ? hold_q : shifter_q) : '0;
    assign serial_out   = serial_out_q;
    assign full         = (fill_cnt_q == FULL_C);

endmodule

// File: tb/tb_i4003_ext.sv
// Directed bench for i4003_ext: default, LSB-direction/4-bit and latched instances
// share one stimulus stream; each is checked in its own scenario after a poc.
module tb_i4003_ext;

    localparam int DLY = 13;

    logic       sysclk    = 1'b0;
    logic       poc       = 1'b1;
    logic       cp        = 1'b0;
    logic       serial_in = 1'b0;
    logic       clear     = 1'b0;
    logic       strobe    = 1'b0;
    logic       enable    = 1'b1;

    logic [9:0] def_po, lat_po;
    logic [3:0] lsb_po;
    logic       def_so, def_full, lsb_so, lsb_full, lat_so, lat_full;

    int checks   = 0;
    int failures = 0;

    logic [9:0] pat = 10'b1010000011;

    always #10 sysclk = ~sysclk;

    i4003_ext u_def (
        .sysclk(sysclk), .poc(poc), .cp(cp), .serial_in(serial_in), .clear(clear),
        .strobe(strobe), .enable(enable), .parallel_out(def_po), .serial_out(def_so),
        .full(def_full)
    );

    i4003_ext #(.WIDTH(4), .SHIFT_MSB(0)) u_lsb (
        .sysclk(sysclk), .poc(poc), .cp(cp), .serial_in(serial_in), .clear(clear),
        .strobe(strobe), .enable(enable), .parallel_out(lsb_po), .serial_out(lsb_so),
        .full(lsb_full)
    );

    i4003_ext #(.LATCHED(1)) u_lat (
        .sysclk(sysclk), .poc(poc), .cp(cp), .serial_in(serial_in), .clear(clear),
        .strobe(strobe), .enable(enable), .parallel_out(lat_po), .serial_out(lat_so),
        .full(lat_full)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        serial_in = b;
        cp = 1'b1;
        tick(DLY + 3);
        cp = 1'b0;
        tick(DLY + 3);
        $display("shift serial_in=%0d def_po=%b lsb_po=%b lat_po=%b", b, def_po, lsb_po, lat_po);
    endtask

    task automatic do_poc();
        poc = 1'b1;
        tick(2);
        poc = 1'b0;
        tick(1);
    endtask

    initial begin
        do_poc();
        check_eq("reset_def_po", def_po, 10'd0);
        check_eq("reset_def_so", def_so, 1'b0);
        check_eq("reset_def_full", def_full, 1'b0);
        check_eq("reset_lsb_po", lsb_po, 4'd0);
        check_eq("reset_lat_po", lat_po, 10'd0);

        // Fill the default instance; hold the 10th edge back to probe latency.
        for (int i = 0; i < 9; i++) shift_bit(pat[9-i]);
        check_eq("nine_po", def_po, 10'b0101000001);
        check_eq("nine_full", def_full, 1'b0);
        check_eq("nine_so", def_so, 1'b0);

        serial_in = 1'b1;
        cp = 1'b1;
        tick(DLY + 2);
        check_eq("rise_not_yet", def_po, 10'b0101000001);
        tick(1);
        check_eq("ten_po", def_po, 10'b1010000011);
        check_eq("ten_full", def_full, 1'b1);
        cp = 1'b0;
        tick(DLY + 2);
        check_eq("fall_not_yet", def_so, 1'b0);
        tick(1);
        check_eq("fall_so", def_so, 1'b1);
        $display("txn fill10 po=%b full=%0d so=%0d", def_po, def_full, def_so);

        enable = 1'b0;
        #1;
        check_eq("enable_off", def_po, 10'd0);
        enable = 1'b1;
        #1;

        // Glitch of exactly DLY cycles is rejected.
        serial_in = 1'b0;
        cp = 1'b1;
        tick(DLY);
        cp = 1'b0;
        tick(DLY + 4);
        check_eq("glitch_po", def_po, 10'b1010000011);
        check_eq("glitch_cnt", u_def.dly_cnt_q, 4'd0);

        // DLY+1 cycles is exactly one shift; fill count saturates.
        cp = 1'b1;
        tick(DLY + 1);
        cp = 1'b0;
        tick(2 * DLY + 6);
        check_eq("min_pulse_po", def_po, 10'b0100000110);
        check_eq("sat_full", def_full, 1'b1);
        check_eq("min_pulse_so", def_so, 1'b0);
        $display("txn filter po=%b", def_po);

        // Clear coincident with an accepted rising edge.
        serial_in = 1'b1;
        cp = 1'b1;
        tick(DLY + 2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_eq("clear_po", def_po, 10'd0);
        check_eq("clear_full", def_full, 1'b0);
        cp = 1'b0;
        tick(DLY + 3);
        shift_bit(1'b1);
        check_eq("post_clear_po", def_po, 10'd1);
        check_eq("post_clear_full", def_full, 1'b0);

        // poc in the middle of a pending edge.
        cp = 1'b1;
        tick(9);
        check_eq("mid_cnt", u_def.dly_cnt_q, 4'd7);
        poc = 1'b1;
        #2;
        check_eq("poc_po", def_po, 10'd0);
        check_eq("poc_so", def_so, 1'b0);
        check_eq("poc_full", def_full, 1'b0);
        check_eq("poc_cnt", u_def.dly_cnt_q, 4'd0);
        tick(1);
        poc = 1'b0;
        serial_in = 1'b1;
        tick(DLY + 2);
        check_eq("repoc_not_yet", def_po, 10'd0);
        tick(1);
        check_eq("repoc_rise", def_po, 10'd1);
        cp = 1'b0;
        tick(DLY + 3);
        $display("txn poc_mid po=%b", def_po);

        // Shift toward LSB, 4 bits.
        do_poc();
        shift_bit(1'b1);
        shift_bit(1'b0);
        shift_bit(1'b0);
        check_eq("lsb_so_pre", lsb_so, 1'b0);
        shift_bit(1'b0);
        check_eq("lsb_po", lsb_po, 4'b0001);
        check_eq("lsb_full", lsb_full, 1'b1);
        check_eq("lsb_so", lsb_so, 1'b1);
        shift_bit(1'b1);
        check_eq("lsb_po2", lsb_po, 4'b1000);
        check_eq("lsb_so2", lsb_so, 1'b0);

        // Latched output.
        do_poc();
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b0);
        shift_bit(1'b1);
        shift_bit(1'b1);
        check_eq("lat_prestrobe", lat_po, 10'd0);
        strobe = 1'b1;
        tick(1);
        strobe = 1'b0;
        check_eq("lat_strobe", lat_po, 10'b0000011011);
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b1);
        check_eq("lat_hold", lat_po, 10'b0000011011);
        check_eq("lat_def_live", def_po, 10'b0011011111);
        enable = 1'b0;
        #1;
        check_eq("lat_enable_off", lat_po, 10'd0);
        enable = 1'b1;
        #1;

        // Strobe coincident with an accepted shift captures the shifted value.
        serial_in = 1'b0;
        cp = 1'b1;
        tick(DLY + 2);
        strobe = 1'b1;
        tick(1);
        strobe = 1'b0;
        check_eq("lat_strobe_shift", lat_po, 10'b0110111110);
        cp = 1'b0;
        tick(DLY + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
